tx_fh_dds_spi: RTL and testbench



---
 rtl/tx_fh_pkg.sv | 32 +++
 rtl/dds_spi_shift.sv | 84 ++++++++
 rtl/tx_fh_dds_spi.sv | 166 ++++++++++++++++
 tb/tb_tx_fh_dds_spi.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_fh_pkg.sv
// Shared definitions for the hop-control DDS writer: AD9957 register map,
// serial frame length and the controller state encoding.
package tx_fh_pkg;

  localparam int AD9957_FRAME_LEN = 72;

  localparam logic [4:0] AD9957_REG_CFR1     = 5'h00;
  localparam logic [4:0] AD9957_REG_CFR2     = 5'h01;
  localparam logic [4:0] AD9957_REG_CFR3     = 5'h02;
  localparam logic [4:0] AD9957_REG_AUX_DAC  = 5'h03;
  localparam logic [4:0] AD9957_REG_IOUP_RT  = 5'h04;
  localparam logic [4:0] AD9957_REG_PROFILE0 = 5'h0E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_IOUP
  } state_e;

  // Write instruction byte followed by the 64-bit single-tone profile payload.
  function automatic logic [AD9957_FRAME_LEN-1:0] build_frame(
    input logic [4:0]  addr,
    input logic [13:0] asf,
    input logic [15:0] pow,
    input logic [31:0] ftw
  );
    return {1'b0, 2'b00, addr, 2'b00, asf, pow, ftw};
  endfunction

endpackage

// File: rtl/dds_spi_shift.sv
// SCLK divider, 72-bit MSB-first shift register and bit counter. sdio only
// moves on an sclk fall, so the DDS always samples a settled bit on the rise.
module dds_spi_shift
  import tx_fh_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [AD9957_FRAME_LEN-1:0] frame,
  input  logic                        start,
  output logic                        sclk,
  output logic                        sdio,
  output logic                        last_bit
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  logic [DIV_W-1:0]            div_q, div_d;
  logic                        sclk_q, sclk_d;
  logic                        active_q, active_d;
  logic [6:0]                  bit_q, bit_d;
  logic [AD9957_FRAME_LEN-1:0] sr_q, sr_d;
  logic                        half_end;

  assign half_end = active_q && (div_q == DIV_W'(CLK_DIV - 1));
  // Strobe in the final cycle of bit 0's high phase.
  assign last_bit = half_end && sclk_q && (bit_q == 7'd0);

  always_comb begin
    div_d    = div_q;
    sclk_d   = sclk_q;
    active_d = active_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    if (load) begin
      sr_d = frame;
    end
    if (start) begin
      active_d = 1'b1;
      div_d    = '0;
      sclk_d   = 1'b0;
      bit_d    = 7'(AD9957_FRAME_LEN - 1);
    end else if (active_q) begin
      if (half_end) begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          sr_d   = {sr_q[AD9957_FRAME_LEN-2:0], 1'b0};
          if (bit_q == 7'd0) begin
            active_d = 1'b0;
          end else begin
            bit_d = bit_q - 7'd1;
          end
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      sclk_q   <= 1'b0;
      active_q <= 1'b0;
      bit_q    <= '0;
      sr_q     <= '0;
    end else begin
      div_q    <= div_d;
      sclk_q   <= sclk_d;
      active_q <= active_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
    end
  end

  assign sclk = sclk_q;
  assign sdio = sr_q[AD9957_FRAME_LEN-1];

endmodule

// File: rtl/tx_fh_dds_spi.sv
// Captures the FTW on each freq_en rise and writes it to the AD9957 profile
// register over 3-wire SPI, then pulses IO_UPDATE. One request may queue.
module tx_fh_dds_spi
  import tx_fh_pkg::*;
#(
  parameter int         CLK_DIV      = 4,
  parameter logic [4:0] PROFILE_ADDR = AD9957_REG_PROFILE0,
  parameter logic [13:0] ASF         = 14'h3FFF,
  parameter logic [15:0] POW         = 16'h0,
  parameter int         IOUP_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] freq_factor,
  input  logic        freq_en,
  output logic        spi_csb,
  output logic        spi_sclk,
  output logic        spi_sdio,
  output logic        io_update,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output state_e      dbg_state
);

  localparam int CNT_MAX = (CLK_DIV > IOUP_CYCLES) ? CLK_DIV : IOUP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             freq_en_d_q;
  logic             csb_q, csb_d;
  logic             io_update_q, io_update_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic             pending_q, pending_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             request;
  logic             sh_load, sh_start, sh_last;

  // A request is the rising edge of freq_en; a held level counts once.
  assign request = freq_en & ~freq_en_d_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    csb_d       = csb_q;
    io_update_d = io_update_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    overrun_d   = 1'b0;
    pending_d   = pending_q;
    shadow_d    = shadow_q;
    sh_load     = 1'b0;
    sh_start    = 1'b0;
    if (request) begin
      shadow_d  = freq_factor;
      overrun_d = pending_q;
      if (state_q != ST_IDLE) begin
        pending_d = 1'b1;
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (request) begin
          state_d = ST_CS_SETUP;
          csb_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          sh_load = 1'b1;
        end
      end
      ST_CS_SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d  = ST_SHIFT;
          sh_start = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (sh_last) begin
          state_d = ST_CS_HOLD;
          cnt_d   = '0;
        end
      end
      ST_CS_HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d     = ST_IOUP;
          csb_d       = 1'b1;
          io_update_d = 1'b1;
          cnt_d       = '0;
        end
      end
      ST_IOUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(IOUP_CYCLES - 1)) begin
          io_update_d = 1'b0;
          done_d      = 1'b1;
          // A queued request restarts in the done cycle with busy kept high.
          if (pending_d) begin
            state_d   = ST_CS_SETUP;
            csb_d     = 1'b0;
            cnt_d     = '0;
            sh_load   = 1'b1;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      freq_en_d_q <= 1'b0;
      csb_q       <= 1'b1;
      io_update_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      pending_q   <= 1'b0;
      shadow_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      freq_en_d_q <= freq_en;
      csb_q       <= csb_d;
      io_update_q <= io_update_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      pending_q   <= pending_d;
      shadow_q    <= shadow_d;
    end
  end

  dds_spi_shift #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .frame   (build_frame(PROFILE_ADDR, ASF, POW, shadow_d)),
    .start   (sh_start),
    .sclk    (spi_sclk),
    .sdio    (spi_sdio),
    .last_bit(sh_last)
  );

  assign spi_csb   = csb_q;
  assign io_update = io_update_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tx_fh_dds_spi.sv
// Bench for tx_fh_dds_spi: two instances (CLK_DIV=4/IOUP=8 and CLK_DIV=1/IOUP=1)
// checked every cycle against a transaction-timeline model plus literal checks.
module tb_tx_fh_dds_spi;
  import tx_fh_pkg::*;

  localparam int D0 = 4, U0 = 8, D1 = 1, U1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [1:0]  fe;
  logic [31:0] ff [2];
  wire  [1:0]  csb, sclk, sdio, ioup, busy, done, ovr;
  state_e      dbg0, dbg1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  tx_fh_dds_spi dut0 (
    .clk(clk), .rst(rst[0]), .freq_factor(ff[0]), .freq_en(fe[0]),
    .spi_csb(csb[0]), .spi_sclk(sclk[0]), .spi_sdio(sdio[0]), .io_update(ioup[0]),
    .busy(busy[0]), .done(done[0]), .overrun(ovr[0]), .dbg_state(dbg0)
  );

  tx_fh_dds_spi #(.CLK_DIV(D1), .IOUP_CYCLES(U1)) dut1 (
    .clk(clk), .rst(rst[1]), .freq_factor(ff[1]), .freq_en(fe[1]),
    .spi_csb(csb[1]), .spi_sclk(sclk[1]), .spi_sdio(sdio[1]), .io_update(ioup[1]),
    .busy(busy[1]), .done(done[1]), .overrun(ovr[1]), .dbg_state(dbg1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Model: t is the cycle index inside the current write (-1 when idle).
  typedef struct {
    int          t;
    bit          pend;
    logic [31:0] shadow;
    logic [31:0] ftw;
    logic        fe_prev;
    bit          done;
    bit          ovr;
  } mstate_t;

  mstate_t m [2];

  function automatic int div_of(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int ioup_of(input int i);
    return (i == 0) ? U0 : U1;
  endfunction

  function automatic logic [71:0] exp_frame(input logic [31:0] ftw);
    return {1'b0, 2'b00, 5'h0E, 2'b00, 14'h3FFF, 16'h0000, ftw};
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic r, input logic f,
                                         input logic [31:0] x, input int d, input int u);
    mstate_t n;
    bit req;
    n = s;
    n.done = 1'b0;
    n.ovr  = 1'b0;
    if (r) begin
      n.t = -1; n.pend = 1'b0; n.shadow = '0; n.ftw = '0; n.fe_prev = 1'b0;
      return n;
    end
    req = f && !s.fe_prev;
    n.fe_prev = f;
    if (req) begin
      n.ovr = s.pend;
      n.shadow = x;
    end
    if (s.t < 0) begin
      if (req) begin
        n.t = 0;
        n.ftw = x;
      end
    end else begin
      if (req) n.pend = 1'b1;
      n.t = s.t + 1;
      if (n.t == 146 * d + u) begin
        n.done = 1'b1;
        if (n.pend) begin
          n.pend = 1'b0; n.t = 0; n.ftw = n.shadow;
        end else begin
          n.t = -1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      m[i] <= model_step(m[i], rst[i], fe[i], ff[i], div_of(i), ioup_of(i));
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare of every output against the model timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        automatic int d = div_of(i);
        automatic int t = m[i].t;
        automatic int e = 146 * d + ioup_of(i);
        automatic logic [5:0] exp_v;
        automatic logic [71:0] fr;
        automatic int idx;
        exp_v[5] = !(t >= 0 && t < 146 * d);
        exp_v[4] = (t >= d && t < 145 * d) && (((t - d) % (2 * d)) >= d);
        exp_v[3] = (t >= 146 * d && t < e);
        exp_v[2] = (t >= 0 && t < e);
        exp_v[1] = m[i].done;
        exp_v[0] = m[i].ovr;
        check($sformatf("outs%0d{csb,sclk,ioup,busy,done,ovr}", i),
              72'({csb[i], sclk[i], ioup[i], busy[i], done[i], ovr[i]}), 72'(exp_v));
        if (t >= 0 && t < 145 * d) begin
          fr  = exp_frame(m[i].ftw);
          idx = (t < d) ? 0 : (t - d) / (2 * d);
          check($sformatf("sdio%0d", i), 72'(sdio[i]), 72'(fr[71 - idx]));
        end
      end
    end
  end

  // Observations of the DUT pins used by the literal checks.
  logic [71:0] cap [2]      = '{default: '0};
  logic [71:0] last_cap [2] = '{default: '0};
  int nbits [2] = '{0, 0};
  int run [2] = '{0, 0};
  int last_len [2] = '{0, 0};
  int ioup_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int ovr_cnt [2] = '{0, 0};
  int fall_cnt [2] = '{0, 0};
  int refall_cnt [2] = '{0, 0};
  int sclk_hi_cnt [2] = '{0, 0};
  int fall_cyc [2] = '{0, 0};
  logic sclk_p [2] = '{1'b0, 1'b0};
  logic csb_p [2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      sclk_p[i] <= sclk[i];
      csb_p[i]  <= csb[i];
      if (sclk[i]) sclk_hi_cnt[i] <= sclk_hi_cnt[i] + 1;
      if (ioup[i]) ioup_cnt[i] <= ioup_cnt[i] + 1;
      if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
      if (ovr[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
      if (done[i] && !csb[i]) refall_cnt[i] <= refall_cnt[i] + 1;
      if (csb_p[i] && !csb[i]) begin
        fall_cnt[i] <= fall_cnt[i] + 1;
        fall_cyc[i] <= cyc;
        cap[i] <= '0;
        nbits[i] <= 0;
      end else if (!csb[i] && sclk[i] && !sclk_p[i]) begin
        cap[i] <= {cap[i][70:0], sdio[i]};
        nbits[i] <= nbits[i] + 1;
      end
      if (!csb[i]) begin
        run[i] <= run[i] + 1;
      end else if (run[i] != 0) begin
        last_len[i] <= run[i];
        last_cap[i] <= cap[i];
        run[i] <= 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int i, input int budget, output int dcyc);
    bit found;
    found = 1'b0;
    dcyc = -1;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk);
      if (done[i]) begin
        found = 1'b1;
        dcyc = cyc;
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL done_timeout%0d: no done within %0d cycles, required one", i, budget);
    end
  endtask

  task automatic rand_run(input int i, input int n, input int p);
    repeat (n) begin
      ff[i] = $urandom;
      if ($urandom_range(0, p) == 0) fe[i] = ~fe[i];
      rst[i] = ($urandom_range(0, 4000) == 0);
      tick(1);
    end
    rst[i] = 1'b0;
    fe[i] = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base2, base3, base4, req_cyc, dc, dc2;
    rst = 2'b11;
    fe  = 2'b00;
    ff[0] = '0;
    ff[1] = '0;

    // 1. reset held three cycles, then a quiet bus
    @(posedge clk);
    #1 chk_en = 1'b1;
    tick(2);
    rst = 2'b00;
    @(negedge clk);
    check("rst_outs0", 72'({csb[0], sclk[0], sdio[0], ioup[0], busy[0], done[0], ovr[0]}), 72'(7'b1000000));
    check("rst_outs1", 72'({csb[1], sclk[1], sdio[1], ioup[1], busy[1], done[1], ovr[1]}), 72'(7'b1000000));
    check("rst_state", 72'({dbg0, dbg1}), 72'({ST_IDLE, ST_IDLE}));
    base = sclk_hi_cnt[0];
    tick(100);
    check("idle_no_sclk", 72'(sclk_hi_cnt[0] - base), 72'd0);

    // 2. single write of 12345678 with freq_en high for 13 cycles
    base = ioup_cnt[0];
    base2 = done_cnt[0];
    ff[0] = 32'h12345678;
    fe[0] = 1'b1;
    req_cyc = cyc;
    tick(13);
    fe[0] = 1'b0;
    ff[0] = 32'hDEADBEEF;
    wait_done(0, 2000, dc);
    check("csb_latency", 72'(fall_cyc[0] - req_cyc), 72'd1);
    check("csb_low_len", 72'(last_len[0]), 72'd584);
    check("frame_bits", last_cap[0], 72'h0E3FFF000012345678);
    check("ioup_width", 72'(ioup_cnt[0] - base), 72'd8);
    tick(5);
    check("done_once", 72'(done_cnt[0] - base2), 72'd1);

    // 3. freq_en held high 2000 cycles gives one write only
    base = done_cnt[0];
    base2 = fall_cnt[0];
    ff[0] = $urandom;
    fe[0] = 1'b1;
    tick(2000);
    fe[0] = 1'b0;
    tick(20);
    check("held_done", 72'(done_cnt[0] - base), 72'd1);
    check("held_frames", 72'(fall_cnt[0] - base2), 72'd1);

    // 4. two rises during a frame: one overrun, latest FTW wins
    base = done_cnt[0];
    base2 = ovr_cnt[0];
    base3 = refall_cnt[0];
    ff[0] = 32'hAAAA5555; fe[0] = 1'b1; tick(2); fe[0] = 1'b0; tick(100);
    ff[0] = 32'h11111111; fe[0] = 1'b1; tick(2); fe[0] = 1'b0; tick(100);
    ff[0] = 32'h0F0F0F0F; fe[0] = 1'b1; tick(2); fe[0] = 1'b0;
    wait_done(0, 2000, dc);
    wait_done(0, 2000, dc);
    tick(5);
    check("ovr_count", 72'(ovr_cnt[0] - base2), 72'd1);
    check("two_done", 72'(done_cnt[0] - base), 72'd2);
    check("frame2_bits", last_cap[0], 72'h0E3FFF00000F0F0F0F);
    check("refall_in_done", 72'(refall_cnt[0] - base3), 72'd1);

    // 5. reset in the middle of bit 30
    ff[0] = $urandom; fe[0] = 1'b1; tick(2); fe[0] = 1'b0;
    base = 0;
    for (int k = 0; k < 1000 && nbits[0] < 42; k++) @(negedge clk);
    check("reach_bit30", 72'(nbits[0] >= 42), 72'd1);
    rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    check("midrst_pins", 72'({csb[0], sclk[0], busy[0]}), 72'(3'b100));
    base = ioup_cnt[0];
    base2 = fall_cnt[0];
    tick(1000);
    check("midrst_no_ioup", 72'(ioup_cnt[0] - base), 72'd0);
    check("midrst_no_frame", 72'(fall_cnt[0] - base2), 72'd0);

    // 6. fast instance: request landing in the done cycle
    ff[1] = 32'hC001D00D; fe[1] = 1'b1; tick(1); fe[1] = 1'b0;
    wait_done(1, 500, dc);
    check("fast_len1", 72'(last_len[1]), 72'd146);
    ff[1] = 32'h5A5AA5A5;
    fe[1] = 1'b1;
    @(posedge clk);
    #1 fe[1] = 1'b0;
    ff[1] = 32'h0;
    wait_done(1, 500, dc2);
    check("fast_len2", 72'(last_len[1]), 72'd146);
    check("fast_bits2", last_cap[1], 72'h0E3FFF00005A5AA5A5);
    check("fast_start", 72'(fall_cyc[1] - dc), 72'd1);

    // randomized traffic on both instances, checked by the per-cycle model
    base4 = total;
    fork
      rand_run(0, 9000, 150);
      rand_run(1, 6000, 40);
    join
    tick(1500);
    check("end_idle", 72'({busy[0], busy[1], csb[0], csb[1]}), 72'(4'b0011));
    check("random_checks_ran", 72'(total - base4 > 1000), 72'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
